// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module  : md_pkg
// Brief   : Shared encodings and defaults for the multiply/divide controller.
// Revision: 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int MD_MULT_CYCLES_DEFAULT = 5;
    localparam int MD_DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Multi-cycle ops are the ones that occupy the unit and drive busy.
    function automatic logic md_is_long(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
// Module  : md_calc
// Brief   : Combinational 64-bit mult/div datapath; result = {HI, LO}.
// Revision: 1.0 - initial release
// ============================================================================
module md_calc
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        w_sdiv;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps cleanly.
    assign w_sdiv  = (op == MD_DIV);
    assign w_dvd   = (w_sdiv && a[31]) ? (32'd0 - a) : a;
    assign w_dvs   = (w_sdiv && b[31]) ? (32'd0 - b) : b;
    assign w_q_mag = w_dvd / w_dvs;
    assign w_r_mag = w_dvd % w_dvs;
    assign w_q     = (w_sdiv && (a[31] ^ b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r     = (w_sdiv && a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    assign div_by_zero = md_is_div(op) && (b == 32'd0);

    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = w_prod_s;
            MD_MULTU: result = w_prod_u;
            MD_DIV,
            MD_DIVU:  result = {w_r, w_q};
            default:  result = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_controller.sv
`default_nettype none
// ============================================================================
// Module  : md_controller
// Brief   : Multi-cycle HI/LO multiply/divide sequencer with stall request.
// Revision: 1.0 - initial release
// ============================================================================
module md_controller
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic        E_start,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        D_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

    md_state_t   r_state;
    md_state_t   w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_long_start;
    logic        w_done;
    logic [63:0] w_result;
    logic        w_div_by_zero;

    md_calc u_calc (
        .op          (r_op),
        .a           (r_a),
        .b           (r_b),
        .result      (w_result),
        .div_by_zero (w_div_by_zero)
    );

    assign w_long_start = E_start && md_is_long(E_md_op);
    assign w_done       = (r_state == ST_RUN) && (r_cnt == 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_long_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_done)       w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                if (w_long_start) begin
                    r_op   <= E_md_op;
                    r_a    <= E_rs_val;
                    r_b    <= E_rt_val;
                    r_cnt  <= md_is_div(E_md_op) ? C_DIV_CNT : C_MULT_CNT;
                    r_busy <= 1'b1;
                end else if (E_start && (E_md_op == MD_MTHI)) begin
                    r_hi <= E_rs_val;
                end else if (E_start && (E_md_op == MD_MTLO)) begin
                    r_lo <= E_rs_val;
                end
            end else begin
                r_cnt <= r_cnt - 4'd1;
                if (w_done) begin
                    r_busy <= 1'b0;
                    // A zero divisor still costs the full latency but leaves HI/LO alone.
                    if (!w_div_by_zero) begin
                        r_hi <= w_result[63:32];
                        r_lo <= w_result[31:0];
                    end
                end
            end
        end
    end

    assign busy     = r_busy;
    assign md_stall = D_is_md && ((r_busy && !reset) || w_long_start);
    assign HI       = r_hi;
    assign LO       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_md_controller
// Brief   : Self-checking bench for md_controller against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_md_controller;

    localparam int C_NMUL = 5;
    localparam int C_NDIV = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_md_op = 4'd0;
    logic        E_start = 1'b0;
    logic [31:0] E_rs_val = 32'd0;
    logic [31:0] E_rt_val = 32'd0;
    logic        D_is_md = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    md_controller #(.MULT_CYCLES(C_NMUL), .DIV_CYCLES(C_NDIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_md_op  (E_md_op),
        .E_start  (E_start),
        .E_rs_val (E_rs_val),
        .E_rt_val (E_rt_val),
        .D_is_md  (D_is_md),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    // Reference: remaining busy cycles plus the operation waiting to commit.
    int          m_rem = 0;
    logic [3:0]  m_op  = 4'd0;
    logic [31:0] m_a   = 32'd0;
    logic [31:0] m_b   = 32'd0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic is_long(input logic [3:0] op);
        return op inside {[4'd1:4'd4]};
    endfunction

    task automatic model_commit();
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = $signed(m_a);
        sb = $signed(m_b);
        ua = {32'd0, m_a};
        ub = {32'd0, m_b};
        case (m_op)
            4'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
            4'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            4'd3: if (m_b != 0) begin
                sp = sa / sb; m_lo = sp[31:0];
                sp = sa % sb; m_hi = sp[31:0];
            end
            4'd4: if (m_b != 0) begin
                up = ua / ub; m_lo = up[31:0];
                up = ua % ub; m_hi = up[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic model_step();
        if (reset) begin
            m_rem = 0; m_op = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) model_commit();
        end else if (E_start) begin
            if (is_long(E_md_op)) begin
                m_op  = E_md_op;
                m_a   = E_rs_val;
                m_b   = E_rt_val;
                m_rem = (E_md_op >= 4'd3) ? C_NDIV : C_NMUL;
            end else if (E_md_op == 4'd5) m_hi = E_rs_val;
            else if (E_md_op == 4'd6) m_lo = E_rs_val;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_rem > 0});
            chk("cyc_hi", HI, m_hi);
            chk("cyc_lo", LO, m_lo);
            chk("cyc_stall", {31'd0, md_stall},
                {31'd0, D_is_md && ((!reset && m_rem > 0) || (E_start && is_long(E_md_op)))});
        end
    end

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic dmd, input int n);
        @(posedge clk); #1;
        E_start = 1'b1; E_md_op = op; E_rs_val = a; E_rt_val = b; D_is_md = dmd;
        @(negedge clk);
        chk({tag, "_stall_c0"}, {31'd0, md_stall}, {31'd0, dmd});
        chk({tag, "_busy_c0"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        E_start = 1'b0; E_md_op = 4'd0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_busy_c%0d", tag, i), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_stall_c%0d", tag, i), {31'd0, md_stall}, {31'd0, dmd});
        end
        @(negedge clk);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_stall_end"}, {31'd0, md_stall}, 32'd0);
        D_is_md = 1'b0;
    endtask

    task automatic pin(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        chk({tag, "_HI"}, HI, ehi);
        chk({tag, "_LO"}, LO, elo);
        chk({tag, "_model_HI"}, m_hi, ehi);
        chk({tag, "_model_LO"}, m_lo, elo);
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        E_start = 1'b1; E_md_op = op; E_rs_val = v;
        @(posedge clk); #1;
        E_start = 1'b0; E_md_op = 4'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        pin("reset", 32'h0, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, C_NMUL);
        pin("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, C_NMUL);
        pin("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, C_NDIV);
        pin("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div0", 4'd3, 32'd1234, 32'd0, 1'b0, C_NDIV);
        pin("div0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, C_NDIV);
        pin("divovf", 32'h0000_0000, 32'h8000_0000);
        run_op("divu", 4'd4, 32'd100, 32'd7, 1'b0, C_NDIV);
        pin("divu", 32'd2, 32'd14);

        move(4'd5, 32'h1234_5678);
        @(negedge clk);
        pin("mthi", 32'h1234_5678, 32'd14);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        move(4'd6, 32'hCAFE_F00D);
        move(4'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        pin("mtlo", 32'h1234_5678, 32'hCAFE_F00D);

        // Reset lands in the third busy cycle of a mult.
        @(posedge clk); #1;
        E_start = 1'b1; E_md_op = 4'd1; E_rs_val = 32'd3; E_rt_val = 32'd5;
        @(posedge clk); #1;
        E_start = 1'b0; E_md_op = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        pin("abort", 32'h0, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        pin("abort_late", 32'h0, 32'h0);

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            reset    = ($urandom_range(79) == 0);
            E_start  = ($urandom_range(2) == 0);
            E_md_op  = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(6));
            E_rs_val = $urandom;
            case ($urandom_range(7))
                0: E_rt_val = 32'd0;
                1: E_rt_val = $urandom_range(9);
                2: begin E_rs_val = 32'h8000_0000; E_rt_val = 32'hFFFF_FFFF; end
                default: E_rt_val = $urandom;
            endcase
            D_is_md  = $urandom_range(1);
        end
        @(posedge clk); #1;
        E_start = 1'b0; reset = 1'b0; D_is_md = 1'b0;
        repeat (C_NDIV + 2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
